// File: rtl/mtm_alu_seq_ctrl.sv
// Frame sequencer for the serial ALU: deserializer -> ALU core -> serializer.
// Bad frames bypass the core; a watchdog drops frames whose core never answers.
module mtm_alu_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             des_valid,
    input  logic             des_frame_err,
    input  logic             des_crc_err,
    output logic             des_ack,
    output logic             core_start,
    input  logic             core_done,
    input  logic             core_op_err,
    output logic             ser_req,
    input  logic             ser_ack,
    input  logic             ser_busy,
    output logic             ser_sel,
    output logic [2:0]       err_flags,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT_CORE, SEND, WAIT_SER} state_t;

    state_t           state, state_nxt;
    logic [WD_W-1:0]  wdog;
    logic             accept, bad_frame, core_fin, wd_expire, ser_take;
    logic             des_ack_nxt, core_start_nxt, timeout_nxt, ser_sel_nxt;
    logic [2:0]       err_flags_nxt;
    logic [CNT_W-1:0] frame_cnt_nxt, err_cnt_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept    = (state == IDLE) && des_valid;
    assign bad_frame = des_frame_err || des_crc_err;
    assign core_fin  = (state == WAIT_CORE) && core_done;
    // core_done on the final watchdog cycle takes priority over the abort
    assign wd_expire = (state == WAIT_CORE) && !core_done &&
                       (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign ser_req   = (state == SEND) && !ser_busy;
    assign ser_take  = ser_req && ser_ack;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wdog       <= '0;
            des_ack    <= 1'b0;
            core_start <= 1'b0;
            timeout    <= 1'b0;
            ser_sel    <= 1'b0;
            err_flags  <= 3'b000;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            wdog       <= accept ? '0 : (state == WAIT_CORE) ? wdog + WD_W'(1) : wdog;
            des_ack    <= des_ack_nxt;
            core_start <= core_start_nxt;
            timeout    <= timeout_nxt;
            ser_sel    <= ser_sel_nxt;
            err_flags  <= err_flags_nxt;
            frame_cnt  <= frame_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = bad_frame ? SEND : WAIT_CORE;
            WAIT_CORE: if (core_fin) state_nxt = SEND;
                       else if (wd_expire) state_nxt = IDLE;
            SEND:      if (ser_take) state_nxt = WAIT_SER;
            WAIT_SER:  if (!ser_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        des_ack_nxt    = accept;
        core_start_nxt = accept && !bad_frame;
        timeout_nxt    = wd_expire;
        ser_sel_nxt    = ser_sel;
        err_flags_nxt  = err_flags;
        frame_cnt_nxt  = accept ? sat_inc(frame_cnt) : frame_cnt;
        err_cnt_nxt    = (wd_expire || (ser_take && ser_sel)) ? sat_inc(err_cnt) : err_cnt;
        if (accept) begin
            ser_sel_nxt   = bad_frame;
            err_flags_nxt = bad_frame ? {des_frame_err, des_crc_err, 1'b0} : 3'b000;
        end else if (core_fin) begin
            ser_sel_nxt   = core_op_err;
            err_flags_nxt = {err_flags[2:1], core_op_err};
        end
    end

endmodule

// File: tb/tb_mtm_alu_seq_ctrl.sv
// Directed bench for mtm_alu_seq_ctrl with TIMEOUT_CYCLES=8 and CNT_W=4.
module tb_mtm_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       des_valid = 1'b0, des_frame_err = 1'b0, des_crc_err = 1'b0;
    logic       core_done = 1'b0, core_op_err = 1'b0;
    logic       ser_ack = 1'b0, ser_busy = 1'b0;
    logic       des_ack, core_start, ser_req, ser_sel, timeout, busy;
    logic [2:0] err_flags;
    logic [3:0] frame_cnt, err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mtm_alu_seq_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .des_valid(des_valid), .des_frame_err(des_frame_err), .des_crc_err(des_crc_err),
        .des_ack(des_ack), .core_start(core_start),
        .core_done(core_done), .core_op_err(core_op_err),
        .ser_req(ser_req), .ser_ack(ser_ack), .ser_busy(ser_busy), .ser_sel(ser_sel),
        .err_flags(err_flags), .timeout(timeout), .busy(busy),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_des_ack", 32'(des_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: good frame
        des_valid = 1'b1;
        step();
        chk("t1_des_ack", 32'(des_ack), 32'd1);
        chk("t1_core_start", 32'(core_start), 32'd1);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        des_valid = 1'b0;
        step();
        chk("t1_des_ack_pulse", 32'(des_ack), 32'd0);
        chk("t1_core_start_pulse", 32'(core_start), 32'd0);
        step(); step(); step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("t1_ser_req6", 32'(ser_req), 32'd1);
        chk("t1_ser_sel", 32'(ser_sel), 32'd0);
        chk("t1_err_flags", 32'(err_flags), 32'd0);
        step();
        chk("t1_ser_req7", 32'(ser_req), 32'd1);
        ser_ack = 1'b1;
        step();
        ser_ack = 1'b0;
        ser_busy = 1'b1;
        chk("t1_ser_req8", 32'(ser_req), 32'd0);
        repeat (12) step();
        chk("t1_busy20", 32'(busy), 32'd1);
        ser_busy = 1'b0;
        step();
        chk("t1_idle21", 32'(busy), 32'd0);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);

        // 2: CRC error frame bypasses the core
        des_valid = 1'b1; des_crc_err = 1'b1;
        step();
        des_valid = 1'b0; des_crc_err = 1'b0;
        chk("t2_core_start", 32'(core_start), 32'd0);
        chk("t2_ser_sel", 32'(ser_sel), 32'd1);
        chk("t2_err_flags", 32'(err_flags), 32'b010);
        chk("t2_ser_req", 32'(ser_req), 32'd1);
        ser_ack = 1'b1;
        step();
        ser_ack = 1'b0;
        chk("t2_err_cnt", 32'(err_cnt), 32'd1);
        step();
        chk("t2_idle", 32'(busy), 32'd0);

        // 3: opcode error from core
        des_valid = 1'b1;
        step();
        des_valid = 1'b0;
        chk("t3_core_start", 32'(core_start), 32'd1);
        core_done = 1'b1; core_op_err = 1'b1;
        step();
        core_done = 1'b0; core_op_err = 1'b0;
        chk("t3_ser_sel", 32'(ser_sel), 32'd1);
        chk("t3_err_flags", 32'(err_flags), 32'b001);
        ser_ack = 1'b1;
        step();
        ser_ack = 1'b0;
        chk("t3_err_cnt", 32'(err_cnt), 32'd2);
        step();
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);

        // 4: hung core, watchdog fires 8 cycles after core_start
        des_valid = 1'b1;
        step();
        des_valid = 1'b0;
        chk("t4_core_start", 32'(core_start), 32'd1);
        repeat (7) step();
        chk("t4_no_timeout_yet", 32'(timeout), 32'd0);
        chk("t4_busy_before", 32'(busy), 32'd1);
        step();
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_err_cnt", 32'(err_cnt), 32'd3);
        step();
        chk("t4_timeout_pulse", 32'(timeout), 32'd0);

        // 5: core_done on the expiry cycle, serializer busy entering SEND
        des_valid = 1'b1;
        step();
        des_valid = 1'b0;
        repeat (7) step();
        core_done = 1'b1; ser_busy = 1'b1;
        step();
        core_done = 1'b0;
        chk("t5_no_timeout", 32'(timeout), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_req_held_low", 32'(ser_req), 32'd0);
        step(); step();
        chk("t5_req_still_low", 32'(ser_req), 32'd0);
        ser_busy = 1'b0;
        #1;
        chk("t5_req_after_busy", 32'(ser_req), 32'd1);
        ser_ack = 1'b1;
        step();
        ser_ack = 1'b0;
        step();
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_err_cnt", 32'(err_cnt), 32'd3);
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd5);

        // 6: asynchronous reset mid-WAIT_CORE and mid-SEND
        des_valid = 1'b1;
        step();
        des_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6a_core_start", 32'(core_start), 32'd0);
        chk("t6a_busy", 32'(busy), 32'd0);
        chk("t6a_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6a_err_cnt", 32'(err_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        des_valid = 1'b1; des_crc_err = 1'b1;
        step();
        des_valid = 1'b0; des_crc_err = 1'b0;
        chk("t6b_in_send", 32'(ser_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6b_ser_req", 32'(ser_req), 32'd0);
        chk("t6b_ser_sel", 32'(ser_sel), 32'd0);
        chk("t6b_err_flags", 32'(err_flags), 32'd0);
        chk("t6b_des_ack", 32'(des_ack), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // saturation: 17 CRC-error frames with CNT_W=4
        for (int i = 0; i < 17; i++) begin
            des_valid = 1'b1; des_crc_err = 1'b1;
            step();
            des_valid = 1'b0; des_crc_err = 1'b0;
            ser_ack = 1'b1;
            step();
            ser_ack = 1'b0;
            step();
        end
        chk("t6_frame_cnt_sat", 32'(frame_cnt), 32'd15);
        chk("t6_err_cnt_sat", 32'(err_cnt), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
